// File: rtl/switch_allocator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_pkg
// Description : Shared NoC router types, port indices and XY route helper.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

    typedef enum logic [2:0] {
        PORT_N = 3'd0,
        PORT_S = 3'd1,
        PORT_E = 3'd2,
        PORT_W = 3'd3,
        PORT_L = 3'd4
    } port_e;

    localparam int NUM_PORTS   = 5;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_COORD_W = 4;

    // Destination X occupies the top COORD_W bits, destination Y the next field down.
    function automatic int dest_x_msb(input int data_w);
        return data_w - 1;
    endfunction

    function automatic int dest_y_msb(input int data_w, input int coord_w);
        return data_w - 1 - coord_w;
    endfunction

    function automatic logic [2:0] port_wrap(input int idx);
        return 3'(idx % NUM_PORTS);
    endfunction

    function automatic port_e xy_route(input logic [31:0] dest_x, input logic [31:0] dest_y,
                                       input logic [31:0] here_x, input logic [31:0] here_y);
        port_e dir;
        dir = PORT_L;
        if (dest_x > here_x)      dir = PORT_E;
        else if (dest_x < here_x) dir = PORT_W;
        else if (dest_y > here_y) dir = PORT_N;
        else if (dest_y < here_y) dir = PORT_S;
        return dir;
    endfunction

endpackage
`default_nettype wire

// File: rtl/switch_allocator_if.sv
`default_nettype none
// ============================================================================
// Module      : switch_allocator_if
// Description : Input-queue heads, pops, output flits and handshakes of a router.
// Revision    : 1.0 - initial release
// ============================================================================
interface switch_allocator_if import noc_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W
);
    logic [DATA_W-1:0] north_q_i, south_q_i, east_q_i, west_q_i, local_q_i;
    logic              valid_n_i, valid_s_i, valid_e_i, valid_w_i, valid_l_i;
    logic              pop_req_n_o, pop_req_s_o, pop_req_e_o, pop_req_w_o, pop_req_l_o;
    logic [DATA_W-1:0] north_o, south_o, east_o, west_o, local_o;
    logic              north_v_o, south_v_o, east_v_o, west_v_o, local_v_o;
    logic              ready_n_i, ready_s_i, ready_e_i, ready_w_i, ready_l_i;

    modport master (
        output north_q_i, south_q_i, east_q_i, west_q_i, local_q_i,
        output valid_n_i, valid_s_i, valid_e_i, valid_w_i, valid_l_i,
        output ready_n_i, ready_s_i, ready_e_i, ready_w_i, ready_l_i,
        input  pop_req_n_o, pop_req_s_o, pop_req_e_o, pop_req_w_o, pop_req_l_o,
        input  north_o, south_o, east_o, west_o, local_o,
        input  north_v_o, south_v_o, east_v_o, west_v_o, local_v_o
    );

    modport slave (
        input  north_q_i, south_q_i, east_q_i, west_q_i, local_q_i,
        input  valid_n_i, valid_s_i, valid_e_i, valid_w_i, valid_l_i,
        input  ready_n_i, ready_s_i, ready_e_i, ready_w_i, ready_l_i,
        output pop_req_n_o, pop_req_s_o, pop_req_e_o, pop_req_w_o, pop_req_l_o,
        output north_o, south_o, east_o, west_o, local_o,
        output north_v_o, south_v_o, east_v_o, west_v_o, local_v_o
    );
endinterface
`default_nettype wire

// File: rtl/switch_allocator_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : 5-way round-robin arbiter; pointer moves past each winner.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter import noc_pkg::*; (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic                 free_i,
    output logic [NUM_PORTS-1:0] gnt_o
);
    logic [2:0] ptr_q, ptr_d;
    logic       w_found;

    always_comb begin
        gnt_o   = '0;
        ptr_d   = ptr_q;
        w_found = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (free_i && !w_found && req_i[port_wrap(int'(ptr_q) + k)]) begin
                gnt_o[port_wrap(int'(ptr_q) + k)] = 1'b1;
                ptr_d   = port_wrap(int'(ptr_q) + k + 1);
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= 3'd0;
        else     ptr_q <= ptr_d;
    end
endmodule
`default_nettype wire

// File: rtl/switch_allocator.sv
`default_nettype none
// ============================================================================
// Module      : switch_allocator
// Description : XY-routed 5x5 switch allocator with per-output RR arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_allocator import noc_pkg::*; #(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int COORD_W = DEF_COORD_W,
    parameter int X_ID    = 0,
    parameter int Y_ID    = 0
) (
    input  logic              clk,
    input  logic              rst,
    switch_allocator_if.slave bus
);
    localparam int DX_MSB = dest_x_msb(DATA_W);
    localparam int DY_MSB = dest_y_msb(DATA_W, COORD_W);

    logic [DATA_W-1:0]    w_flit [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_valid, w_ready, w_free, w_pop;
    logic [NUM_PORTS-1:0] w_req  [NUM_PORTS];   // [output][input]
    logic [NUM_PORTS-1:0] w_gnt  [NUM_PORTS];   // [output][input]
    port_e                w_route[NUM_PORTS];

    logic [DATA_W-1:0]    out_data_q [NUM_PORTS];
    logic [DATA_W-1:0]    out_data_d [NUM_PORTS];
    logic [NUM_PORTS-1:0] out_v_q, out_v_d;

    assign w_flit[PORT_N] = bus.north_q_i;
    assign w_flit[PORT_S] = bus.south_q_i;
    assign w_flit[PORT_E] = bus.east_q_i;
    assign w_flit[PORT_W] = bus.west_q_i;
    assign w_flit[PORT_L] = bus.local_q_i;
    assign w_valid = {bus.valid_l_i, bus.valid_w_i, bus.valid_e_i, bus.valid_s_i, bus.valid_n_i};
    assign w_ready = {bus.ready_l_i, bus.ready_w_i, bus.ready_e_i, bus.ready_s_i, bus.ready_n_i};

    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) w_req[o] = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_route[i] = xy_route(32'(w_flit[i][DX_MSB -: COORD_W]),
                                  32'(w_flit[i][DY_MSB -: COORD_W]),
                                  32'(X_ID), 32'(Y_ID));
            if (w_valid[i]) w_req[w_route[i]][i] = 1'b1;
        end
    end

    generate
        for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
            // Drain-and-refill: a full register whose flit leaves this cycle is free.
            assign w_free[o] = (!out_v_q[o] || w_ready[o]) && !rst;

            rr_arbiter u_arb (
                .clk    (clk),
                .rst    (rst),
                .req_i  (w_req[o]),
                .free_i (w_free[o]),
                .gnt_o  (w_gnt[o])
            );
        end
    endgenerate

    always_comb begin
        w_pop = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                w_pop[i] = w_pop[i] | w_gnt[o][i];
            end
        end
    end

    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            out_data_d[o] = out_data_q[o];
            out_v_d[o]    = out_v_q[o] && !w_ready[o];
            if (|w_gnt[o]) begin
                out_v_d[o] = 1'b1;
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (w_gnt[o][i]) out_data_d[o] = w_flit[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_v_q <= '0;
            for (int o = 0; o < NUM_PORTS; o++) out_data_q[o] <= '0;
        end else begin
            out_v_q <= out_v_d;
            for (int o = 0; o < NUM_PORTS; o++) out_data_q[o] <= out_data_d[o];
        end
    end

    assign bus.pop_req_n_o = w_pop[PORT_N];
    assign bus.pop_req_s_o = w_pop[PORT_S];
    assign bus.pop_req_e_o = w_pop[PORT_E];
    assign bus.pop_req_w_o = w_pop[PORT_W];
    assign bus.pop_req_l_o = w_pop[PORT_L];

    assign bus.north_o = out_data_q[PORT_N];
    assign bus.south_o = out_data_q[PORT_S];
    assign bus.east_o  = out_data_q[PORT_E];
    assign bus.west_o  = out_data_q[PORT_W];
    assign bus.local_o = out_data_q[PORT_L];

    assign bus.north_v_o = out_v_q[PORT_N];
    assign bus.south_v_o = out_v_q[PORT_S];
    assign bus.east_v_o  = out_v_q[PORT_E];
    assign bus.west_v_o  = out_v_q[PORT_W];
    assign bus.local_v_o = out_v_q[PORT_L];
endmodule
`default_nettype wire

// File: tb/tb_switch_allocator.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_allocator
// Description : Directed self-checking bench for switch_allocator at (1,1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_allocator;
    import noc_pkg::*;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] q [5];
    logic [4:0]    vin;
    logic [4:0]    rdy;
    logic [4:0]    pops;
    logic [4:0]    vouts;
    logic [DW-1:0] outd [5];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            order [3] = '{0, 1, 3};

    always #5 clk = ~clk;

    switch_allocator_if #(.DATA_W(DW)) bus ();

    assign bus.north_q_i = q[0];
    assign bus.south_q_i = q[1];
    assign bus.east_q_i  = q[2];
    assign bus.west_q_i  = q[3];
    assign bus.local_q_i = q[4];
    assign bus.valid_n_i = vin[0];
    assign bus.valid_s_i = vin[1];
    assign bus.valid_e_i = vin[2];
    assign bus.valid_w_i = vin[3];
    assign bus.valid_l_i = vin[4];
    assign bus.ready_n_i = rdy[0];
    assign bus.ready_s_i = rdy[1];
    assign bus.ready_e_i = rdy[2];
    assign bus.ready_w_i = rdy[3];
    assign bus.ready_l_i = rdy[4];
    assign pops  = {bus.pop_req_l_o, bus.pop_req_w_o, bus.pop_req_e_o, bus.pop_req_s_o, bus.pop_req_n_o};
    assign vouts = {bus.local_v_o, bus.west_v_o, bus.east_v_o, bus.south_v_o, bus.north_v_o};
    assign outd[0] = bus.north_o;
    assign outd[1] = bus.south_o;
    assign outd[2] = bus.east_o;
    assign outd[3] = bus.west_o;
    assign outd[4] = bus.local_o;

    switch_allocator #(.DATA_W(DW), .COORD_W(4), .X_ID(1), .Y_ID(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int dx, input int dy, input logic [23:0] pl);
        return {4'(dx), 4'(dy), pl};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        for (int i = 0; i < 5; i++) q[i] = '0;
        vin = '0;
        rdy = 5'b11111;

        // Reset with a pending local flit: no pops, everything cleared
        q[4] = mk(3, 1, 24'hA1A1A1);
        vin  = 5'b10000;
        tick();
        tick();
        check("rst_pops", 32'(pops), 32'h0);
        check("rst_vouts", 32'(vouts), 32'h0);
        check("rst_east_data", outd[2], 32'h0);
        check("rst_local_data", outd[4], 32'h0);

        // Local flit to (3,1) goes east with one cycle latency
        rst = 1'b0;
        settle();
        check("l2e_pop", 32'(pops), 32'h10);
        tick();
        vin = '0;
        check("l2e_data", outd[2], 32'h31A1A1A1);
        check("l2e_vouts", 32'(vouts), 32'h04);
        settle();
        tick();
        check("l2e_drain_v", 32'(vouts), 32'h0);
        check("l2e_drain_hold", outd[2], 32'h31A1A1A1);

        // N, S, W all to local: round robin N, S, W
        q[0] = mk(1, 1, 24'h000001);
        q[1] = mk(1, 1, 24'h000002);
        q[3] = mk(1, 1, 24'h000004);
        vin  = 5'b01011;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("rr_pop", 32'(pops), 32'(1 << order[k]));
            tick();
            vin[3'(order[k])] = 1'b0;
            check("rr_local_data", outd[4], q[order[k]]);
            check("rr_local_v", 32'(vouts), 32'h10);
        end
        settle();
        tick();
        check("rr_drain_v", 32'(vouts), 32'h0);

        // East stalls for 4 cycles with a second flit waiting
        rdy  = 5'b11011;
        q[4] = mk(3, 1, 24'h0000AA);
        vin  = 5'b10000;
        settle();
        check("stall_first_pop", 32'(pops), 32'h10);
        tick();
        q[4] = mk(3, 1, 24'h0000BB);
        check("stall_first_data", outd[2], 32'h310000AA);
        check("stall_first_v", 32'(vouts), 32'h04);
        for (int k = 0; k < 4; k++) begin
            settle();
            check("stall_no_pop", 32'(pops), 32'h0);
            tick();
            check("stall_hold_data", outd[2], 32'h310000AA);
            check("stall_hold_v", 32'(vouts), 32'h04);
        end
        rdy = 5'b11111;
        settle();
        check("stall_release_pop", 32'(pops), 32'h10);
        tick();
        vin = '0;
        check("stall_second_data", outd[2], 32'h310000BB);
        settle();
        tick();

        // All five inputs to distinct outputs in one cycle
        q[0] = mk(2, 1, 24'h00E0E0);
        q[1] = mk(0, 1, 24'h00D0D0);
        q[2] = mk(1, 2, 24'h00C0C0);
        q[3] = mk(1, 0, 24'h00B0B0);
        q[4] = mk(1, 1, 24'h00A0A0);
        vin  = 5'b11111;
        settle();
        check("all5_pops", 32'(pops), 32'h1F);
        tick();
        vin = '0;
        check("all5_vouts", 32'(vouts), 32'h1F);
        check("all5_east", outd[2], q[0]);
        check("all5_west", outd[3], q[1]);
        check("all5_north", outd[0], q[2]);
        check("all5_south", outd[1], q[3]);
        check("all5_local", outd[4], q[4]);
        settle();
        tick();

        // Three outputs full and stalled, then reset mid-operation
        rdy  = '0;
        q[0] = mk(2, 1, 24'h000011);
        q[1] = mk(0, 1, 24'h000022);
        q[4] = mk(1, 1, 24'h000033);
        vin  = 5'b10011;
        settle();
        check("pre_rst_pops", 32'(pops), 32'h13);
        tick();
        vin = '0;
        check("pre_rst_vouts", 32'(vouts), 32'h1C);
        rst  = 1'b1;
        q[3] = mk(3, 1, 24'h000044);
        vin  = 5'b01001;
        settle();
        check("mid_rst_pops", 32'(pops), 32'h0);
        tick();
        check("mid_rst_vouts", 32'(vouts), 32'h0);
        check("mid_rst_east", outd[2], 32'h0);
        rst = 1'b0;
        rdy = 5'b11111;
        settle();
        check("post_rst_first_pop", 32'(pops), 32'h01);
        tick();
        vin[0] = 1'b0;
        check("post_rst_first_data", outd[2], q[0]);
        settle();
        check("post_rst_second_pop", 32'(pops), 32'h08);
        tick();
        vin = '0;
        check("post_rst_second_data", outd[2], q[3]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/switch_allocator.md
SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 Parameter DATA_W, default 32, flit width in bits.
REQ-002 Parameter COORD_W, default 4, width of each destination coordinate field.
REQ-003 Parameter X_ID, default 0, this router's X coordinate.
REQ-004 Parameter Y_ID, default 0, this router's Y coordinate.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 north_q_i, south_q_i, east_q_i, west_q_i, local_q_i  in  DATA_W  head flit of each input queue.
REQ-008 valid_n_i, valid_s_i, valid_e_i, valid_w_i, valid_l_i  in  1  input queue non-empty; head flit valid.
REQ-009 pop_req_n_o, pop_req_s_o, pop_req_e_o, pop_req_w_o, pop_req_l_o  out  1  pop head of that input queue this cycle.
REQ-010 north_o, south_o, east_o, west_o, local_o  out  DATA_W  registered output flit per output port.
REQ-011 north_v_o, south_v_o, east_v_o, west_v_o, local_v_o  out  1  output flit valid.
REQ-012 ready_n_i, ready_s_i, ready_e_i, ready_w_i, ready_l_i  in  1  downstream accepts flit on that port this cycle.

Function
REQ-013 Every flit is a single-flit packet; dest_x = flit[DATA_W-1 -: COORD_W], dest_y = next COORD_W bits below; remaining bits are payload, forwarded unchanged.
REQ-014 Dimension-ordered XY routing, unsigned compare: dest_x>X_ID -> east; dest_x<X_ID -> west; else dest_y>Y_ID -> north; dest_y<Y_ID -> south; else local.
REQ-015 Each valid input requests exactly one output per cycle; invalid inputs request nothing.
REQ-016 Each output port has an output register (flit + valid) and a 5-way round-robin arbiter, index order N=0, S=1, E=2, W=3, L=4.
REQ-017 Output port is free when its valid is 0 or its ready is 1 in the same cycle (drain and refill in one cycle).
REQ-018 Grant occurs only to a requesting input on a free output; at most one grant per output per cycle.
REQ-019 Arbiter searches from its priority pointer upward (mod 5); first requester wins.
REQ-020 On grant to index i, pointer becomes (i+1) mod 5 at next edge; with no grant, pointer holds.
REQ-021 pop_req_x_o is combinational and asserted in the same cycle its input is granted; never asserted while valid_x_i=0.
REQ-022 Granted flit appears on the output register with valid=1 at the next rising edge (latency 1 cycle).
REQ-023 Output valid=1 with ready=0 holds flit and valid unchanged (stall); no grant to that port.
REQ-024 Output valid=1, ready=1, no new grant -> valid clears next edge; data holds last value.
REQ-025 Different outputs grant independently in the same cycle; up to 5 grants per cycle.
REQ-026 A flit destined for its own arrival direction is routed per REQ-014 without special handling.

Reset
REQ-027 While rst=1: all pop_req_*_o=0, all *_v_o=0 at next edge, all output data=0, all priority pointers=0 (north highest).
REQ-028 Reset mid-operation discards registered output flits; queue contents are untouched since no pop occurs.

Structure
REQ-029 Shared package noc_pkg holds port index enum (N,S,E,W,L), NUM_PORTS=5, DATA_W/COORD_W defaults, dest field positions and an XY route function.
REQ-030 One sub-module rr_arbiter (5 request bits, free, 5 grant bits, internal pointer) instantiated once per output port.

Verification
REQ-031 X_ID=Y_ID=1; local input flit dest (3,1) -> pop_req_l_o=1 same cycle, east_o=flit, east_v_o=1 next cycle.
REQ-032 N,S,W all valid with dest (1,1), ready_l_i=1 for 3 cycles -> local grants N, S, W in consecutive cycles.
REQ-033 east_v_o=1, ready_e_i=0 for 4 cycles with local flit to east pending -> east_o stable, pop_req_l_o=0 throughout; granted the cycle ready_e_i=1.
REQ-034 Five inputs valid, each to a distinct output, all ready=1 -> all five pops same cycle, all five valids next cycle.
REQ-035 Assert rst while three outputs valid -> all *_v_o=0 next edge, no pops; after release first contested grant goes to lowest requesting index.
